mash_dsm_gen: RTL

//  Parametrised MASH-1-1-1 delta-sigma modulator, the next generation of the project DSM top.

---
 rtl/mash_dsm_gen_if.sv | 26 ++
 rtl/mash_dsm_gen.sv | 139 +++++++++++++
 2 files changed

// File: rtl/mash_dsm_gen_if.sv
// Control/data bundle between the frequency-word source and the MASH modulator.
// The master drives the word and strobes; the slave returns the modulated code.
interface mash_dsm_gen_if #(
  parameter int INT_W  = 4,
  parameter int FRAC_W = 16,
  parameter int OUT_W  = 4
);
  logic              ld;
  logic [INT_W-1:0]  in_i;
  logic [FRAC_W-1:0] in_f;
  logic              en;
  logic              clr;
  logic [OUT_W-1:0]  out;
  logic              out_vld;
  logic              sat;

  modport master (
    output ld, in_i, in_f, en, clr,
    input  out, out_vld, sat
  );

  modport slave (
    input  ld, in_i, in_f, en, clr,
    output out, out_vld, sat
  );
endinterface

// File: rtl/mash_dsm_gen.sv
// Parametrised MASH-1-1-1 delta-sigma modulator with clamp, optional LFSR dither,
// load strobe, clock enable and accumulator clear.
module mash_dsm_gen #(
  parameter int INT_W   = 4,
  parameter int FRAC_W  = 16,
  parameter int OUT_W   = 4,
  parameter int ORDER   = 3,
  parameter int OUT_MIN = 0,
  parameter int OUT_MAX = 15,
  parameter int DITHER  = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  mash_dsm_gen_if.slave       bus
);
  localparam int VW = INT_W + 3;

  if (ORDER < 1 || ORDER > 3) begin : g_bad_order
    $error("mash_dsm_gen: ORDER must be 1, 2 or 3");
  end
  if (OUT_MAX > (2 ** OUT_W) - 1 || OUT_MIN > OUT_MAX) begin : g_bad_clamp
    $error("mash_dsm_gen: clamp limits do not fit OUT_W");
  end

  logic [INT_W-1:0]  i_reg;
  logic [FRAC_W-1:0] f_reg;
  logic [15:0]       lfsr_reg;
  logic [15:0]       lfsr_next;
  logic              c2d_reg, c3d_reg, c3dd_reg;
  logic [OUT_W-1:0]  out_reg;
  logic              out_vld_reg;
  logic              sat_reg;
  logic              dither_bit;

  assign dither_bit = (DITHER != 0) ? lfsr_reg[0] : 1'b0;
  assign lfsr_next  = {lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5], lfsr_reg[15:1]};

  // Each active stage integrates the previous stage's new residue; inactive stages
  // exist only as a constant-zero carry so the output combiner stays uniform.
  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_stage
    logic carry;
    if (gi < ORDER) begin : g_on
      logic [FRAC_W-1:0] acc_reg;
      logic [FRAC_W-1:0] addend;
      logic              cin;
      logic [FRAC_W:0]   sum;
      logic [FRAC_W-1:0] low;

      if (gi == 0) begin : g_first
        assign addend = f_reg;
        assign cin    = dither_bit;
      end else begin : g_chain
        assign addend = g_stage[gi-1].g_on.low;
        assign cin    = 1'b0;
      end

      assign sum   = {1'b0, acc_reg} + {1'b0, addend} + {{FRAC_W{1'b0}}, cin};
      assign low   = sum[FRAC_W-1:0];
      assign carry = sum[FRAC_W];

      always_ff @(posedge clk) begin
        if (!rst_n || bus.clr) begin
          acc_reg <= '0;
        end else if (bus.en) begin
          acc_reg <= low;
        end
      end
    end else begin : g_off
      assign carry = 1'b0;
    end
  end

  logic               c1, c2, c3;
  logic [VW-1:0]      y;
  logic [VW-1:0]      v;
  logic signed [31:0] v_ext;
  logic signed [31:0] clamp_val;
  logic [OUT_W-1:0]   out_next;
  logic               sat_next;

  assign c1 = g_stage[0].carry;
  assign c2 = g_stage[1].carry;
  assign c3 = g_stage[2].carry;

  // Two's-complement arithmetic in VW bits; y spans -3..+4 so i_reg + y never wraps.
  always_comb begin
    y         = VW'(c1) + VW'(c2) - VW'(c2d_reg) + VW'(c3) - (VW'(c3d_reg) << 1) + VW'(c3dd_reg);
    v         = {3'b000, i_reg} + y;
    v_ext     = {{(32-VW){v[VW-1]}}, v};
    clamp_val = v_ext;
    if (v_ext < OUT_MIN) begin
      clamp_val = OUT_MIN;
    end else if (v_ext > OUT_MAX) begin
      clamp_val = OUT_MAX;
    end
    out_next = clamp_val[OUT_W-1:0];
    sat_next = (clamp_val != v_ext);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_reg       <= '0;
      f_reg       <= '0;
      lfsr_reg    <= 16'hACE1;
      c2d_reg     <= 1'b0;
      c3d_reg     <= 1'b0;
      c3dd_reg    <= 1'b0;
      out_reg     <= '0;
      out_vld_reg <= 1'b0;
      sat_reg     <= 1'b0;
    end else begin
      if (bus.ld) begin
        i_reg <= bus.in_i;
        f_reg <= bus.in_f;
      end
      if (bus.clr) begin
        c2d_reg     <= 1'b0;
        c3d_reg     <= 1'b0;
        c3dd_reg    <= 1'b0;
        out_vld_reg <= 1'b0;
      end else if (bus.en) begin
        c2d_reg     <= c2;
        c3d_reg     <= c3;
        c3dd_reg    <= c3d_reg;
        out_reg     <= out_next;
        sat_reg     <= sat_next;
        out_vld_reg <= 1'b1;
        lfsr_reg    <= lfsr_next;
      end else begin
        out_vld_reg <= 1'b0;
      end
    end
  end

  assign bus.out     = out_reg;
  assign bus.out_vld = out_vld_reg;
  assign bus.sat     = sat_reg;
endmodule
